// File: rtl/adaptive_sampling_pkg.sv
// Shared types and constants for the two-channel adaptive sampling scheduler.
package adaptive_sampling_pkg;

  // ADC arbiter states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Channel indices as seen on adc_ch
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // Default lower clamp on a nonzero sample interval, in clk cycles
  localparam int unsigned MIN_INTERVAL_DEF = 16;

  // Width of the optional per-channel overrun event counters
  localparam int unsigned OVR_CNT_W = 16;

  // Round-robin pick: with both requesting, serve the channel not served last
  function automatic logic rr_pick(input logic [1:0] req, input logic last_served);
    if (&req) begin
      return ~last_served;
    end
    return req[CH_B];
  endfunction

endpackage

// File: rtl/interval_divider.sv
// Sequential restoring divider producing a sample interval = period / target.
// A zero target disables the channel (result 0); a nonzero quotient below
// MIN_INTERVAL is raised to MIN_INTERVAL. A new load while busy restarts.
// Result appears PERIOD_W+2 cycles after the load cycle.
module interval_divider
  import adaptive_sampling_pkg::*;
#(
  parameter int unsigned PERIOD_W     = 32,
  parameter int unsigned TARGET_W     = 10,
  parameter int unsigned MIN_INTERVAL = MIN_INTERVAL_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [TARGET_W-1:0] target_i,
  output logic [PERIOD_W-1:0] interval_o
);

  localparam int unsigned STEP_W = $clog2(PERIOD_W + 1);

  logic                busy_q;
  logic [STEP_W-1:0]   step_q;
  logic [PERIOD_W-1:0] quo_q;
  logic [TARGET_W-1:0] rem_q;
  logic [TARGET_W-1:0] div_q;
  logic [PERIOD_W-1:0] interval_q;

  logic [TARGET_W:0]   rem_sh_c;
  logic                ge_c;
  logic [TARGET_W-1:0] rem_d;
  logic [PERIOD_W-1:0] quo_d;
  logic [PERIOD_W-1:0] result_c;

  // One restoring shift-subtract step and the final clamp/disable mapping
  always_comb begin
    rem_sh_c = {rem_q, quo_q[PERIOD_W-1]};
    ge_c     = (rem_sh_c >= {1'b0, div_q});
    rem_d    = ge_c ? TARGET_W'(rem_sh_c - {1'b0, div_q}) : TARGET_W'(rem_sh_c);
    quo_d    = {quo_q[PERIOD_W-2:0], ge_c};
    result_c = quo_q;
    if (div_q == '0) begin
      result_c = '0;
    end else if ((quo_q != '0) && (quo_q < PERIOD_W'(MIN_INTERVAL))) begin
      result_c = PERIOD_W'(MIN_INTERVAL);
    end
  end

  // Load / iterate / publish sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= 1'b0;
      step_q     <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      interval_q <= '0;
    end else if (load_i) begin
      busy_q <= 1'b1;
      step_q <= '0;
      quo_q  <= period_i;
      rem_q  <= '0;
      div_q  <= target_i;
    end else if (busy_q) begin
      if (step_q == STEP_W'(PERIOD_W)) begin
        busy_q     <= 1'b0;
        interval_q <= result_c;
      end else begin
        step_q <= step_q + STEP_W'(1);
        quo_q  <= quo_d;
        rem_q  <= rem_d;
      end
    end
  end

  assign interval_o = interval_q;

endmodule

// File: rtl/two_ch_sample_scheduler.sv
// Two-channel ADC sample scheduler: per-channel interval dividers and
// countdown counters raise requests that a round-robin arbiter serves on a
// shared ADC through a start/done handshake. Late requests set sticky overrun.
// Optional build macro SCHED_OVERRUN_CNT_EN adds saturating overrun counters.
module two_ch_sample_scheduler
  import adaptive_sampling_pkg::*;
#(
  parameter int unsigned PERIOD_W     = 32,
  parameter int unsigned TARGET_W     = 10,
  parameter int unsigned MIN_INTERVAL = MIN_INTERVAL_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period_A,
  input  logic [PERIOD_W-1:0] period_B,
  input  logic                period_valid_A,
  input  logic                period_valid_B,
  input  logic [TARGET_W-1:0] sample_target_A,
  input  logic [TARGET_W-1:0] sample_target_B,
  output logic                adc_start,
  output logic                adc_ch,
  input  logic                adc_done,
  output logic [PERIOD_W-1:0] interval_A,
  output logic [PERIOD_W-1:0] interval_B,
  output logic                overrun_A,
  output logic                overrun_B,
  input  logic                overrun_clr
`ifdef SCHED_OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] overrun_cnt_A,
  output logic [OVR_CNT_W-1:0] overrun_cnt_B
`endif
);

  logic [PERIOD_W-1:0] period_w   [2];
  logic [TARGET_W-1:0] target_w   [2];
  logic [PERIOD_W-1:0] interval_w [2];
  logic [1:0]          valid_w;
  logic [1:0]          tick_c;
  logic [1:0]          clr_c;
  logic [1:0]          ovr_set_c;
  logic [1:0]          pending_c;
  logic [1:0]          overrun_c;
`ifdef SCHED_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ocnt_w [2];
`endif

  arb_state_e state_q;
  logic       adc_start_q;
  logic       adc_ch_q;
  logic       last_q;

  assign period_w[CH_A] = period_A;
  assign period_w[CH_B] = period_B;
  assign target_w[CH_A] = sample_target_A;
  assign target_w[CH_B] = sample_target_B;
  assign valid_w        = {period_valid_B, period_valid_A};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [PERIOD_W-1:0] cnt_q;
    logic                run_q;
    logic                pend_q;
    logic                ovr_q;

    interval_divider #(
      .PERIOD_W     (PERIOD_W),
      .TARGET_W     (TARGET_W),
      .MIN_INTERVAL (MIN_INTERVAL)
    ) u_div (
      .clk        (clk),
      .reset      (reset),
      .load_i     (valid_w[c]),
      .period_i   (period_w[c]),
      .target_i   (target_w[c]),
      .interval_o (interval_w[c])
    );

    // Countdown from interval-1; a fresh enable loads without ticking
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        run_q <= 1'b0;
      end else if (interval_w[c] == '0) begin
        cnt_q <= '0;
        run_q <= 1'b0;
      end else if (!run_q || (cnt_q == '0)) begin
        cnt_q <= interval_w[c] - PERIOD_W'(1);
        run_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - PERIOD_W'(1);
      end
    end

    assign tick_c[c]    = run_q && (cnt_q == '0) && (interval_w[c] != '0);
    assign clr_c[c]     = (state_q == WAIT) && adc_done && (adc_ch_q == 1'(c));
    assign ovr_set_c[c] = tick_c[c] && pend_q && !clr_c[c];

    // Pending request (tick wins over a same-cycle clear) and sticky overrun
    always_ff @(posedge clk) begin
      if (reset) begin
        pend_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        pend_q <= (pend_q && !clr_c[c]) || tick_c[c];
        ovr_q  <= overrun_clr ? 1'b0 : (ovr_q || ovr_set_c[c]);
      end
    end

    assign pending_c[c] = pend_q;
    assign overrun_c[c] = ovr_q;

`ifdef SCHED_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] ocnt_q;

    // Saturating count of overrun events
    always_ff @(posedge clk) begin
      if (reset || overrun_clr) begin
        ocnt_q <= '0;
      end else if (ovr_set_c[c] && (ocnt_q != '1)) begin
        ocnt_q <= ocnt_q + OVR_CNT_W'(1);
      end
    end

    assign ocnt_w[c] = ocnt_q;
`endif
  end

  // Round-robin arbiter driving the shared ADC handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      adc_start_q <= 1'b0;
      adc_ch_q    <= CH_A;
      last_q      <= CH_B;
    end else begin
      adc_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|pending_c) begin
            adc_ch_q    <= rr_pick(pending_c, last_q);
            adc_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (adc_done) begin
            last_q  <= adc_ch_q;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign adc_start  = adc_start_q;
  assign adc_ch     = adc_ch_q;
  assign interval_A = interval_w[CH_A];
  assign interval_B = interval_w[CH_B];
  assign overrun_A  = overrun_c[CH_A];
  assign overrun_B  = overrun_c[CH_B];
`ifdef SCHED_OVERRUN_CNT_EN
  assign overrun_cnt_A = ocnt_w[CH_A];
  assign overrun_cnt_B = ocnt_w[CH_B];
`endif

endmodule

// File: tb/tb_two_ch_sample_scheduler.sv
// Scoreboard bench for two_ch_sample_scheduler. A time-based reference model
// (absolute tick times, request flags, ADC busy windows) pushes expected
// starts and status snapshots; a negedge monitor pops and compares.
module tb_two_ch_sample_scheduler;

  localparam int unsigned PW   = 32;
  localparam int unsigned TW   = 10;
  localparam int unsigned MINV = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] period_A, period_B;
  logic          period_valid_A, period_valid_B;
  logic [TW-1:0] sample_target_A, sample_target_B;
  logic          adc_start, adc_ch, adc_done;
  logic [PW-1:0] interval_A, interval_B;
  logic          overrun_A, overrun_B, overrun_clr;
`ifdef SCHED_OVERRUN_CNT_EN
  logic [15:0]   overrun_cnt_A, overrun_cnt_B;
`endif

  two_ch_sample_scheduler #(.PERIOD_W(PW), .TARGET_W(TW), .MIN_INTERVAL(MINV)) dut (
    .clk             (clk),
    .reset           (reset),
    .period_A        (period_A),
    .period_B        (period_B),
    .period_valid_A  (period_valid_A),
    .period_valid_B  (period_valid_B),
    .sample_target_A (sample_target_A),
    .sample_target_B (sample_target_B),
    .adc_start       (adc_start),
    .adc_ch          (adc_ch),
    .adc_done        (adc_done),
    .interval_A      (interval_A),
    .interval_B      (interval_B),
    .overrun_A       (overrun_A),
    .overrun_B       (overrun_B),
    .overrun_clr     (overrun_clr)
`ifdef SCHED_OVERRUN_CNT_EN
    ,
    .overrun_cnt_A   (overrun_cnt_A),
    .overrun_cnt_B   (overrun_cnt_B)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint      cyc;
    bit          is_start;
    bit          ch;
    int unsigned iv0, iv1;
    bit          ov0, ov1;
    int unsigned oc0, oc1;
    bit          chv;
  } exp_t;

  exp_t   sb_q[$];
  int     n_cmp  = 0;
  int     n_fail = 0;
  longint n      = 0;
  bit     mon_en = 1'b0;

  // Reference model state (values visible in the current cycle)
  int unsigned iv[2];
  longint      nt[2];
  bit          pend[2];
  bit          ovr[2];
  int unsigned ocnt[2];
  int          phase;      // 0 idle, 1 start pulse, 2 awaiting done
  bit          gnt, last, ch_vis;
  longint      done_time;
  longint      upd_time[2];
  int unsigned upd_val[2];

  // Stimulus requests for the next step
  bit          rq_valid[2];
  int unsigned rq_p[2], rq_t[2];
  bit          rq_clr, rq_rst, rq_done_force, rq_chk;
  bit          withhold, spurious;
  int          lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, req, n);
    end
  endtask

  function automatic int unsigned exp_interval(input int unsigned p, input int unsigned t);
    int unsigned qv;
    if (t == 0) return 0;
    qv = p / t;
    if (qv != 0 && qv < MINV) return MINV;
    return qv;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      iv[c] = 0; nt[c] = -1; pend[c] = 0; ovr[c] = 0; ocnt[c] = 0; upd_time[c] = -1;
    end
    phase = 0; gnt = 0; last = 1; ch_vis = 0; done_time = 0;
  endtask

  task automatic step();
    bit     tick[2];
    bit     clr[2];
    bit     done;
    bit     hit;
    exp_t   e;
    @(posedge clk);
    #1;
    n++;
    hit = rq_chk;
    for (int c = 0; c < 2; c++) begin
      if (upd_time[c] == n) begin
        if (iv[c] == 0 && upd_val[c] != 0) nt[c] = n + upd_val[c];
        iv[c] = upd_val[c];
        upd_time[c] = -1;
        hit = 1;
      end
      if (upd_time[c] == n + 1) hit = 1;
    end
    if (phase == 1) begin
      e = '{cyc: n, is_start: 1, ch: gnt, iv0: 0, iv1: 0, ov0: 0, ov1: 0, oc0: 0, oc1: 0, chv: 0};
      sb_q.push_back(e);
    end
    if (hit || (n % 32 == 0)) begin
      e = '{cyc: n, is_start: 0, ch: 0, iv0: iv[0], iv1: iv[1], ov0: ovr[0], ov1: ovr[1],
            oc0: ocnt[0], oc1: ocnt[1], chv: ch_vis};
      sb_q.push_back(e);
    end
    done = rq_done_force || (phase == 2 && !withhold && n >= done_time) ||
           (spurious && phase != 2 && $urandom_range(0, 49) == 0);
    reset           = rq_rst;
    adc_done        = done;
    overrun_clr     = rq_clr;
    period_valid_A  = rq_valid[0];
    period_valid_B  = rq_valid[1];
    period_A        = rq_valid[0] ? rq_p[0] : $urandom;
    period_B        = rq_valid[1] ? rq_p[1] : $urandom;
    sample_target_A = rq_valid[0] ? TW'(rq_t[0]) : TW'($urandom);
    sample_target_B = rq_valid[1] ? TW'(rq_t[1]) : TW'($urandom);
    if (rq_rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < 2; c++) begin
        tick[c] = (iv[c] != 0) && (nt[c] == n);
        if (tick[c]) nt[c] = n + iv[c];
        clr[c] = (phase == 2) && done && (gnt == c[0]);
      end
      case (phase)
        0: if (pend[0] || pend[1]) begin
             gnt    = (pend[0] && pend[1]) ? !last : pend[1];
             ch_vis = gnt;
             phase  = 1;
           end
        1: begin phase = 2; done_time = n + lat; end
        default: if (done) begin last = gnt; phase = 0; end
      endcase
      for (int c = 0; c < 2; c++) begin
        if (rq_clr) begin
          ovr[c] = 0; ocnt[c] = 0;
        end else if (tick[c] && pend[c] && !clr[c]) begin
          ovr[c] = 1;
          if (ocnt[c] != 16'hFFFF) ocnt[c]++;
        end
        pend[c] = (pend[c] && !clr[c]) || tick[c];
        if (rq_valid[c]) begin
          upd_time[c] = n + PW + 2;
          upd_val[c]  = exp_interval(rq_p[c], rq_t[c]);
        end
      end
    end
    rq_valid = '{0, 0}; rq_clr = 0; rq_rst = 0; rq_done_force = 0; rq_chk = 0;
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic set_ch(input int c, input int unsigned p, input int unsigned t);
    rq_valid[c] = 1; rq_p[c] = p; rq_t[c] = t;
  endtask

  // Monitor: pop expectations for this cycle and compare against the DUT
  exp_t m_e;
  bit   m_se, m_sch;
  always @(negedge clk) begin
    if (mon_en) begin
      m_se = 0; m_sch = 0;
      while (sb_q.size() > 0 && sb_q[0].cyc <= n) begin
        m_e = sb_q.pop_front();
        if (m_e.is_start) begin
          m_se = 1; m_sch = m_e.ch;
        end else begin
          chk("interval_A", interval_A, m_e.iv0);
          chk("interval_B", interval_B, m_e.iv1);
          chk("overrun_A", overrun_A, m_e.ov0);
          chk("overrun_B", overrun_B, m_e.ov1);
          chk("adc_ch_hold", adc_ch, m_e.chv);
`ifdef SCHED_OVERRUN_CNT_EN
          chk("overrun_cnt_A", overrun_cnt_A, m_e.oc0);
          chk("overrun_cnt_B", overrun_cnt_B, m_e.oc1);
`endif
        end
      end
      if (adc_start !== 1'b0 || m_se) begin
        chk("adc_start", adc_start, m_se);
        if (m_se) chk("adc_ch", adc_ch, m_sch);
      end
    end
  end

  initial begin
    int k;
    reset = 1; adc_done = 0; overrun_clr = 0;
    period_valid_A = 0; period_valid_B = 0;
    period_A = 0; period_B = 0; sample_target_A = 0; sample_target_B = 0;
    rq_valid = '{0, 0}; rq_p = '{0, 0}; rq_t = '{0, 0};
    rq_clr = 0; rq_done_force = 0; rq_chk = 0; withhold = 0; spurious = 0; lat = 5;
    model_reset();
    repeat (2) @(posedge clk);
    mon_en = 1;
    rq_rst = 1; step();
    rq_chk = 1; step();

    // Single channel, with a superseded load first
    set_ch(0, 10000, 50); step();
    run(5);
    set_ch(0, 10000, 100); step();
    run(450);

    // Equal intervals on both channels
    rq_rst = 1; step();
    set_ch(0, 10000, 100); set_ch(1, 10000, 100); step();
    run(450);

    // Disable B, then clamp A
    set_ch(1, 10000, 0); step();
    run(300);
    set_ch(0, 100, 100); step();
    run(200);

    // Overrun: withhold adc_done across several ticks, then clear
    rq_rst = 1; step();
    set_ch(0, 10000, 100); step();
    run(40);
    withhold = 1;
    run(330);
    rq_chk = 1; rq_clr = 1; step();
    rq_chk = 1; step();
    withhold = 0;
    run(200);

    // Reset while waiting for adc_done, then a late done pulse
    rq_rst = 1; step();
    lat = 8;
    set_ch(0, 10000, 100); step();
    k = 0;
    while (adc_start !== 1'b1 && k < 400) begin step(); k++; end
    chk("start_timeout", (k < 400), 1);
    rq_rst = 1; step();
    rq_done_force = 1; rq_chk = 1; step();
    run(200);

    // Randomized traffic
    spurious = 1;
    rq_rst = 1; step();
    for (int i = 0; i < 4000; i++) begin
      lat = $urandom_range(1, 12);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 249) == 0) begin
          int unsigned t;
          t = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1023);
          set_ch(c, $urandom_range(0, 300) * ((t == 0) ? 1 : t) + $urandom_range(0, 1000), t);
        end
      end
      if ($urandom_range(0, 399) == 0) rq_clr = 1;
      if ($urandom_range(0, 1999) == 0) rq_rst = 1;
      step();
    end
    spurious = 0;
    run(20);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
